fp_adder_tree_arbiter: RTL

// - Shares one pipelined fp_adder_tree among NUM_REQUESTERS clients using round-robin arbitration.
// - Issues at most one NUM_INPUTS-wide vector per cycle and tags each issue with its requester id.
// - Returns each scalar sum to the requester that issued it.
// - Sits between LCMV datapath units, which need row/column sums, and the single shared adder tree.

---
 rtl/fp_adder_tree_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fp_adder_tree_arbiter.sv
// Round-robin front end sharing one pipelined fp adder tree among several clients.
// Optional FP_ARB_TAG_CHECK_EN builds a sticky tag/valid alignment checker driving tag_err.
module fp_adder_tree_arbiter #(
    parameter int WIDTH          = 32,
    parameter int NUM_INPUTS     = 7,
    parameter int NUM_REQUESTERS = 4,
    parameter int TREE_LATENCY   = 36
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQUESTERS-1:0]                 req_valid,
    input  logic [NUM_REQUESTERS*NUM_INPUTS*WIDTH-1:0] req_data,
    output logic [NUM_REQUESTERS-1:0]                 req_ack,
    output logic [WIDTH-1:0]                          res_data,
    output logic [NUM_REQUESTERS-1:0]                 res_valid,
    output logic [NUM_INPUTS*WIDTH-1:0]               tree_in,
    output logic                                      tree_ready,
    input  logic [WIDTH-1:0]                          tree_out,
    input  logic                                      tree_valid,
    output logic                                      tag_err
);

    localparam int ID_W  = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam int VEC_W = NUM_INPUTS * WIDTH;
    localparam int TAG_W = ID_W + 1;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             tree_ready_q, tree_ready_d;
    logic [VEC_W-1:0] tree_in_q, tree_in_d;
    logic [ID_W-1:0]  issue_id_q, issue_id_d;
    logic [TAG_W-1:0] tag_q [TREE_LATENCY];
    logic [TAG_W-1:0] tag_d [TREE_LATENCY];
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [NUM_REQUESTERS-1:0] res_valid_q, res_valid_d;

    logic             grant;
    logic [ID_W-1:0]  grant_id;
    int               idx;

    logic [TAG_W-1:0] tag_out;
    logic             tag_vld;
    logic [ID_W-1:0]  tag_id;

    assign tag_out = tag_q[TREE_LATENCY-1];
    assign tag_vld = tag_out[TAG_W-1];
    assign tag_id  = tag_out[ID_W-1:0];

    // Search from the pointer upward, wrapping once around the requesters.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        idx      = 0;
        req_ack  = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQUESTERS) idx = idx - NUM_REQUESTERS;
            if (!grant && req_valid[ID_W'(idx)]) begin
                grant    = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
        if (rst) grant = 1'b0;
        if (grant) req_ack[grant_id] = 1'b1;
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        tree_ready_d = grant;
        tree_in_d    = tree_in_q;
        issue_id_d   = issue_id_q;
        if (grant) begin
            rr_ptr_d   = (grant_id == ID_W'(NUM_REQUESTERS-1)) ? '0 : grant_id + ID_W'(1);
            issue_id_d = grant_id;
        end
        for (int r = 0; r < NUM_REQUESTERS; r++) begin
            if (grant && grant_id == ID_W'(r)) tree_in_d = req_data[r*VEC_W +: VEC_W];
        end
    end

    // Tag entry 0 captures the issue stage so the last entry lines up with tree_valid.
    always_comb begin
        tag_d[0] = {tree_ready_q, issue_id_q};
        for (int i = 1; i < TREE_LATENCY; i++) tag_d[i] = tag_q[i-1];
    end

    always_comb begin
        res_data_d  = tree_out;
        res_valid_d = '0;
        if (tree_valid && tag_vld) res_valid_d[tag_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            tree_ready_q <= 1'b0;
            tree_in_q    <= '0;
            issue_id_q   <= '0;
            res_data_q   <= '0;
            res_valid_q  <= '0;
            for (int i = 0; i < TREE_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            tree_ready_q <= tree_ready_d;
            tree_in_q    <= tree_in_d;
            issue_id_q   <= issue_id_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            for (int i = 0; i < TREE_LATENCY; i++) tag_q[i] <= tag_d[i];
        end
    end

    assign tree_ready = tree_ready_q;
    assign tree_in    = tree_in_q;
    assign res_data   = res_data_q;
    assign res_valid  = res_valid_q;

`ifdef FP_ARB_TAG_CHECK_EN
    logic tag_err_q, tag_err_d;

    always_comb begin
        tag_err_d = tag_err_q | (tree_valid != tag_vld);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_err_q <= 1'b0;
        end else begin
            tag_err_q <= tag_err_d;
            if (tree_valid != tag_vld)
                $error("fp_adder_tree_arbiter: tree_valid=%0b but tag valid=%0b", tree_valid, tag_vld);
        end
    end

    assign tag_err = tag_err_q;
`else
    assign tag_err = 1'b0;
`endif

endmodule
